// File: rtl/l1_pkg.sv
// Shared L1 data-cache geometry and a one-hot decode helper.
// Other blocks use these values as the defaults for their parameters.
package l1_pkg;

  localparam int WAY_NUM      = 4;
  localparam int IDX_WIDTH    = 7;
  localparam int TAG_WIDTH    = 20;
  localparam int LINE_SIZE    = 256;
  localparam int LD_MEM_WIDTH = TAG_WIDTH + 1;
  localparam int SET_DEPTH    = 1 << IDX_WIDTH;
  localparam int WAY_IDX_W    = $clog2(WAY_NUM);

  // OR of the indices of all set bits; exact for a one-hot input.
  function automatic logic [WAY_IDX_W-1:0] one_hot_to_idx(input logic [WAY_NUM-1:0] oh);
    logic [WAY_IDX_W-1:0] res;
    res = '0;
    for (int i = 0; i < WAY_NUM; i++) begin
      if (oh[i]) begin
        res = res | WAY_IDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/l1_lrum.sv
// Hit detection and true-LRU victim selection using a per-set age rank per way.
// Age 0 is the most recently used way; WAY_NUM-1 is the least recently used.
module l1_lrum
  import l1_pkg::*;
#(
  parameter int WAY_NUM   = l1_pkg::WAY_NUM,
  parameter int IDX_WIDTH = l1_pkg::IDX_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic [IDX_WIDTH-1:0] idx,
  input  logic [WAY_NUM-1:0]   tag_cmp_vect,
  input  logic [WAY_NUM-1:0]   ld_val_vect,
  output logic                 hit,
  output logic                 evict_val,
  output logic [WAY_NUM-1:0]   way_vect
);

  localparam int AW    = $clog2(WAY_NUM);
  localparam int DEPTH = 1 << IDX_WIDTH;
  localparam logic [AW-1:0] LRU_AGE = AW'(WAY_NUM - 1);

  logic [WAY_NUM-1:0][AW-1:0] age_reg [DEPTH];
  logic [WAY_NUM-1:0][AW-1:0] age_row;
  logic [WAY_NUM-1:0][AW-1:0] age_row_next;
  logic [WAY_NUM-1:0]         hit_vect;
  logic [WAY_NUM-1:0]         inv_vect;
  logic [WAY_NUM-1:0]         lru_vect;
  logic [WAY_NUM-1:0]         sel_vect;
  logic [AW-1:0]              sel_idx;
  logic [AW-1:0]              sel_age;

  assign age_row   = age_reg[idx];
  assign hit_vect  = tag_cmp_vect & ld_val_vect;
  assign inv_vect  = ~ld_val_vect;
  assign hit       = |hit_vect;
  assign evict_val = ~hit & (&ld_val_vect);

  generate
    for (genvar gi = 0; gi < WAY_NUM; gi++) begin : g_lru
      assign lru_vect[gi] = (age_row[gi] == LRU_AGE);
    end
  endgenerate

  // x & -x isolates the lowest set bit, giving the lowest-index candidate.
  always_comb begin
    sel_vect = lru_vect;
    if (hit) begin
      sel_vect = hit_vect & (~hit_vect + WAY_NUM'(1));
    end else if (|inv_vect) begin
      sel_vect = inv_vect & (~inv_vect + WAY_NUM'(1));
    end
  end

  assign way_vect = sel_vect;
  assign sel_idx  = one_hot_to_idx(sel_vect);
  assign sel_age  = age_row[sel_idx];

  // Ways younger than the touched way age by one; the touched way becomes MRU.
  generate
    for (genvar gi = 0; gi < WAY_NUM; gi++) begin : g_next
      assign age_row_next[gi] = sel_vect[gi]          ? '0 :
                                (age_row[gi] < sel_age) ? age_row[gi] + AW'(1) :
                                                          age_row[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        for (int w = 0; w < WAY_NUM; w++) begin
          age_reg[s][w] <= AW'(w);
        end
      end
    end else if (req) begin
      age_reg[idx] <= age_row_next;
    end
  end

endmodule

// File: rtl/l1_reg_array.sv
// Generic flop array: asynchronous read, synchronous write with optional byte lanes.
// The read port has no bypass, so a same-cycle read returns the old contents.
module l1_reg_array #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 128,
  parameter bit BYTE_EN = 1'b0,
  localparam int AW     = $clog2(DEPTH),
  localparam int NB     = (WIDTH + 7) / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NB-1:0] wbe
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] bit_mask;

  // Without byte enables every bit lane is always written.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign bit_mask[gi] = wbe[gi / 8] | ~BYTE_EN;
    end
  endgenerate

  assign rdata = mem_reg[raddr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wen) begin
      mem_reg[waddr] <= (mem_reg[waddr] & ~bit_mask) | (wdata & bit_mask);
    end
  end

endmodule

// File: rtl/l1_reg_dm_mem.sv
// Per-way line data array; each write updates only the bytes selected by wbe.
module l1_reg_dm_mem
  import l1_pkg::*;
#(
  parameter int WIDTH = LINE_SIZE,
  parameter int DEPTH = SET_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AW-1:0]      raddr,
  output logic [WIDTH-1:0]   rdata,
  input  logic               wen,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wbe
);

  l1_reg_array #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .BYTE_EN (1'b1)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (raddr),
    .rdata (rdata),
    .wen   (wen),
    .waddr (waddr),
    .wdata (wdata),
    .wbe   (wbe)
  );

endmodule

// File: rtl/l1_reg_ld_mem.sv
// Per-way tag/valid array; the valid bit sits in the MSB of each word.
// Whole-word writes only.
module l1_reg_ld_mem
  import l1_pkg::*;
#(
  parameter int WIDTH = LD_MEM_WIDTH,
  parameter int DEPTH = SET_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int NB   = (WIDTH + 7) / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  l1_reg_array #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .BYTE_EN (1'b0)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (raddr),
    .rdata (rdata),
    .wen   (wen),
    .waddr (waddr),
    .wdata (wdata),
    .wbe   ({NB{1'b1}})
  );

endmodule

// File: rtl/l1d_lru_arrays.sv
// L1D per-set storage slice: LRU/hit logic plus one tag array and one data array per way.
// All ways share read/write addresses and data; each way has its own write enable.
module l1d_lru_arrays
  import l1_pkg::*;
#(
  parameter int WAY_NUM   = l1_pkg::WAY_NUM,
  parameter int IDX_WIDTH = l1_pkg::IDX_WIDTH,
  parameter int TAG_WIDTH = l1_pkg::TAG_WIDTH,
  parameter int LINE_SIZE = l1_pkg::LINE_SIZE,
  localparam int LD_W     = TAG_WIDTH + 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req,
  input  logic [IDX_WIDTH-1:0]               idx,
  input  logic [WAY_NUM-1:0]                 tag_cmp_vect,
  input  logic [WAY_NUM-1:0]                 ld_val_vect,
  output logic                               hit,
  output logic                               evict_val,
  output logic [WAY_NUM-1:0]                 way_vect,
  input  logic [IDX_WIDTH-1:0]               ld_raddr,
  output logic [WAY_NUM-1:0][LD_W-1:0]       ld_rdata,
  input  logic [WAY_NUM-1:0]                 ld_wen,
  input  logic [IDX_WIDTH-1:0]               ld_waddr,
  input  logic [LD_W-1:0]                    ld_wdata,
  input  logic [IDX_WIDTH-1:0]               dm_raddr,
  output logic [WAY_NUM-1:0][LINE_SIZE-1:0]  dm_rdata,
  input  logic [WAY_NUM-1:0]                 dm_wen,
  input  logic [IDX_WIDTH-1:0]               dm_waddr,
  input  logic [LINE_SIZE-1:0]               dm_wdata,
  input  logic [LINE_SIZE/8-1:0]             dm_wbe
);

  localparam int DEPTH = 1 << IDX_WIDTH;

  l1_lrum #(
    .WAY_NUM   (WAY_NUM),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_lrum (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .idx          (idx),
    .tag_cmp_vect (tag_cmp_vect),
    .ld_val_vect  (ld_val_vect),
    .hit          (hit),
    .evict_val    (evict_val),
    .way_vect     (way_vect)
  );

  generate
    for (genvar gi = 0; gi < WAY_NUM; gi++) begin : g_way
      l1_reg_ld_mem #(
        .WIDTH (LD_W),
        .DEPTH (DEPTH)
      ) u_ld_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .raddr (ld_raddr),
        .rdata (ld_rdata[gi]),
        .wen   (ld_wen[gi]),
        .waddr (ld_waddr),
        .wdata (ld_wdata)
      );

      l1_reg_dm_mem #(
        .WIDTH (LINE_SIZE),
        .DEPTH (DEPTH)
      ) u_dm_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .raddr (dm_raddr),
        .rdata (dm_rdata[gi]),
        .wen   (dm_wen[gi]),
        .waddr (dm_waddr),
        .wdata (dm_wdata),
        .wbe   (dm_wbe)
      );
    end
  endgenerate

endmodule

// File: tb/tb_l1d_lru_arrays.sv
// Scoreboard bench for l1d_lru_arrays: directed cases then randomized traffic
// checked against a recency-list and byte-array reference model.
module tb_l1d_lru_arrays;
  import l1_pkg::*;

  localparam int WN = 4;
  localparam int DP = 128;
  localparam int LW = LD_MEM_WIDTH;
  localparam int LS = LINE_SIZE;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   req;
  logic [6:0]             idx;
  logic [WN-1:0]          tag_cmp_vect;
  logic [WN-1:0]          ld_val_vect;
  logic                   hit;
  logic                   evict_val;
  logic [WN-1:0]          way_vect;
  logic [6:0]             ld_raddr;
  logic [WN-1:0][LW-1:0]  ld_rdata;
  logic [WN-1:0]          ld_wen;
  logic [6:0]             ld_waddr;
  logic [LW-1:0]          ld_wdata;
  logic [6:0]             dm_raddr;
  logic [WN-1:0][LS-1:0]  dm_rdata;
  logic [WN-1:0]          dm_wen;
  logic [6:0]             dm_waddr;
  logic [LS-1:0]          dm_wdata;
  logic [LS/8-1:0]        dm_wbe;

  always #5 clk = ~clk;

  l1d_lru_arrays dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .idx          (idx),
    .tag_cmp_vect (tag_cmp_vect),
    .ld_val_vect  (ld_val_vect),
    .hit          (hit),
    .evict_val    (evict_val),
    .way_vect     (way_vect),
    .ld_raddr     (ld_raddr),
    .ld_rdata     (ld_rdata),
    .ld_wen       (ld_wen),
    .ld_waddr     (ld_waddr),
    .ld_wdata     (ld_wdata),
    .dm_raddr     (dm_raddr),
    .dm_rdata     (dm_rdata),
    .dm_wen       (dm_wen),
    .dm_waddr     (dm_waddr),
    .dm_wdata     (dm_wdata),
    .dm_wbe       (dm_wbe)
  );

  typedef struct {
    logic                  hit;
    logic                  evict;
    logic [WN-1:0]         way;
    logic [WN-1:0][LW-1:0] ld;
    logic [WN-1:0][LS-1:0] dm;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   chk      = 1'b0;

  // Reference model: recency list per set (front = MRU) and plain memory images.
  int         rec [DP][$];
  logic [LW-1:0] m_ld [WN][DP];
  logic [LS-1:0] m_dm [WN][DP];

  task automatic reset_model();
    for (int s = 0; s < DP; s++) begin
      rec[s] = {};
      for (int w = 0; w < WN; w++) rec[s].push_back(w);
      for (int w = 0; w < WN; w++) begin
        m_ld[w][s] = '0;
        m_dm[w][s] = '0;
      end
    end
  endtask

  task automatic idle();
    req = 1'b0; idx = '0; tag_cmp_vect = '0; ld_val_vect = '0;
    ld_wen = '0; ld_waddr = '0; ld_wdata = '0; ld_raddr = '0;
    dm_wen = '0; dm_waddr = '0; dm_wdata = '0; dm_wbe = '0; dm_raddr = '0;
  endtask

  // Predict this cycle's outputs, queue them, then advance the model across the edge.
  task automatic step();
    exp_t       e;
    int         w;
    int         p;
    logic [WN-1:0] hv;
    hv = tag_cmp_vect & ld_val_vect;
    w = 0;
    if (hv != 0) begin
      for (int i = WN - 1; i >= 0; i--) if (hv[i]) w = i;
    end else if (ld_val_vect != 4'hF) begin
      for (int i = WN - 1; i >= 0; i--) if (!ld_val_vect[i]) w = i;
    end else begin
      w = rec[idx][WN-1];
    end
    e.hit   = (hv != 0);
    e.evict = (hv == 0) && (ld_val_vect == 4'hF);
    e.way   = 4'(1 << w);
    for (int v = 0; v < WN; v++) begin
      e.ld[v] = m_ld[v][ld_raddr];
      e.dm[v] = m_dm[v][dm_raddr];
    end
    if (chk) sb_q.push_back(e);
    @(posedge clk);
    if (!rst_n) begin
      reset_model();
    end else begin
      if (req) begin
        p = 0;
        for (int i = 0; i < rec[idx].size(); i++) if (rec[idx][i] == w) p = i;
        rec[idx].delete(p);
        rec[idx].push_front(w);
      end
      for (int v = 0; v < WN; v++) begin
        if (ld_wen[v]) m_ld[v][ld_waddr] = ld_wdata;
        if (dm_wen[v]) begin
          for (int k = 0; k < LS / 8; k++)
            if (dm_wbe[k]) m_dm[v][dm_waddr][8*k +: 8] = dm_wdata[8*k +: 8];
        end
      end
    end
    #1;
  endtask

  // Monitor: outputs are combinational, so every queued cycle is checked mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (hit === e.hit && evict_val === e.evict && way_vect === e.way) n_pass++;
      else $display("FAIL lrum: got hit=%0b evict=%0b way=%b, expected hit=%0b evict=%0b way=%b",
                    hit, evict_val, way_vect, e.hit, e.evict, e.way);
      n_checks++;
      if (ld_rdata === e.ld) n_pass++;
      else $display("FAIL ld_rdata @%0d: got %h expected %h", ld_raddr, ld_rdata, e.ld);
      for (int v = 0; v < WN; v++) begin
        n_checks++;
        if (dm_rdata[v] === e.dm[v]) n_pass++;
        else $display("FAIL dm_rdata way%0d @%0d: got %h expected %h", v, dm_raddr, dm_rdata[v], e.dm[v]);
      end
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    reset_model();
    step();
    step();
    chk = 1'b1;
    step();                         // reset state: 0/0 vectors select way 0
    rst_n = 1'b1;

    // dm byte write on way 0, address 5, bytes 4..7
    idle();
    dm_wen = 4'b0001; dm_waddr = 7'd5; dm_wbe = 32'h0000_00F0;
    dm_wdata = {32{8'hAA}};
    step();
    idle(); dm_raddr = 7'd5; step();
    idle(); dm_raddr = 7'd4; step();

    // hit on way 2 with update, then a fill into the invalid way
    idle(); idx = 7'd1; tag_cmp_vect = 4'b0100; ld_val_vect = 4'b1111; req = 1'b1; step();
    idle(); idx = 7'd1; ld_val_vect = 4'b1011; step();

    // touch ways 0..3 in order on set 3, then miss: way 0 is the victim
    for (int w = 0; w < WN; w++) begin
      idle(); idx = 7'd3; ld_val_vect = 4'hF; tag_cmp_vect = 4'(1 << w); req = 1'b1; step();
    end
    idle(); idx = 7'd3; ld_val_vect = 4'hF; step();
    idle(); idx = 7'd4; ld_val_vect = 4'hF; step();

    // tag write then read back
    idle(); ld_wen = 4'b0001; ld_waddr = 7'd9; ld_wdata = {1'b1, 20'hABCDE}; step();
    idle(); ld_raddr = 7'd9; step();

    // randomized traffic on a small address window, with occasional resets
    for (int n = 0; n < 2000; n++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      req          = 1'($urandom_range(0, 1));
      idx          = 7'($urandom_range(0, 3));
      ld_val_vect  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      tag_cmp_vect = ($urandom_range(0, 1) == 1) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      tag_cmp_vect = tag_cmp_vect | (4'($urandom) & ~ld_val_vect);
      ld_wen       = 4'($urandom);
      ld_waddr     = 7'($urandom_range(0, 7));
      ld_wdata     = LW'($urandom);
      ld_raddr     = 7'($urandom_range(0, 7));
      dm_wen       = 4'($urandom);
      dm_waddr     = 7'($urandom_range(0, 7));
      dm_wbe       = 32'($urandom);
      for (int k = 0; k < LS / 32; k++) dm_wdata[32*k +: 32] = $urandom;
      dm_raddr     = 7'($urandom_range(0, 7));
      step();
    end

    chk = 1'b0;
    rst_n = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
